// File: rtl/priority_encoder_scan_if.sv
// Handshake bundle for the scanning priority encoder: input vector channel,
// output code channel, the acceptance gate and the zero-vector error pulse.
interface priority_encoder_scan_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 4
);
   logic             enable;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_vec;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_code;
   logic             out_last;
   logic             zero_err;

   // Upstream/downstream environment side.
   modport master (
      output enable, in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_code, out_last, zero_err
   );

   // Encoder side.
   modport slave (
      input  enable, in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_code, out_last, zero_err
   );
endinterface

// File: rtl/priority_encoder_scan.sv
// Scanning priority encoder: accepts a multi-hot vector, then emits the index
// of every set bit, lowest index first, one code per output handshake.
module priority_encoder_scan #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   priority_encoder_scan_if.slave bus
);

   if (IN_W != 2**OUT_W) begin : g_param_check
      $error("priority_encoder_scan: IN_W must equal 2**OUT_W");
   end

   typedef enum logic {IDLE, EMIT} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IN_W-1:0]  r_pending;
   logic [IN_W-1:0]  w_pending_nxt;
   logic             r_zero_err;
   logic             w_zero_err_nxt;
   logic             w_in_hs;
   logic             w_out_hs;
   logic [OUT_W-1:0] w_code;
   logic             w_last;

   // in_ready is gated by rst_n so it reads 0 for the whole reset window.
   assign bus.in_ready  = rst_n & bus.enable & (r_state == IDLE);
   assign bus.out_valid = (r_state == EMIT);
   assign bus.out_code  = w_code;
   assign bus.out_last  = w_last;
   assign bus.zero_err  = r_zero_err;

   assign w_in_hs  = bus.in_valid & bus.in_ready;
   assign w_out_hs = bus.out_valid & bus.out_ready;

   // Lowest set bit of pending wins; scanning downward lets the last hit stand.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_code = '0;
      for (int i = IN_W - 1; i >= 0; i--) begin
         if (r_pending[i]) w_code = OUT_W'(i);
      end
   end

   // Exactly one bit left: non-zero and clearing its lowest bit empties it.
   assign w_last = (r_pending != '0) &&
                   ((r_pending & (r_pending - IN_W'(1))) == '0);

   // Next state, pending bits and zero-error pulse.
   always_comb begin
      w_state_nxt    = r_state;
      w_pending_nxt  = r_pending;
      w_zero_err_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_in_hs) begin
               if (bus.in_vec != '0) begin
                  w_pending_nxt = bus.in_vec;
                  w_state_nxt   = EMIT;
               end else begin
                  w_zero_err_nxt = 1'b1;
               end
            end
         end
         EMIT: begin
            if (w_out_hs) begin
               // Clearing the lowest set bit drops exactly the code just emitted.
               w_pending_nxt = r_pending & (r_pending - IN_W'(1));
               if (w_last) w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register; reset discards any in-flight vector immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pending  <= '0;
         r_zero_err <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         r_state    <= w_state_nxt;
         r_pending  <= w_pending_nxt;
         r_zero_err <= w_zero_err_nxt;
      end
   end

endmodule

// File: tb/tb_priority_encoder_scan.sv
// Self-checking bench for priority_encoder_scan: a queue-based model of the
// codes still owed, compared every cycle, plus directed literal scenarios.
module tb_priority_encoder_scan;

   localparam int IN_W  = 16;
   localparam int OUT_W = 4;

   logic clk;
   logic rst_n;

   priority_encoder_scan_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   priority_encoder_scan #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the list of indices still to be emitted for the accepted vector.
   int   q_codes[$];
   logic zerr_exp = 1'b0;

   // Compare at the falling edge, then advance the model for the coming edge.
   always @(negedge clk) begin
      logic exp_ready, exp_valid;
      if (!rst_n) begin
         q_codes.delete();
         zerr_exp = 1'b0;
      end
      exp_valid = (q_codes.size() != 0);
      exp_ready = rst_n && bus.enable && !exp_valid;
      check("m_in_ready",  32'(bus.in_ready),  32'(exp_ready));
      check("m_out_valid", 32'(bus.out_valid), 32'(exp_valid));
      check("m_out_code",  32'(bus.out_code),  exp_valid ? 32'(q_codes[0]) : 32'd0);
      check("m_out_last",  32'(bus.out_last),  32'(q_codes.size() == 1));
      check("m_zero_err",  32'(bus.zero_err),  32'(zerr_exp));
      if (rst_n) begin
         zerr_exp = 1'b0;
         if (exp_valid && bus.out_ready) void'(q_codes.pop_front());
         if (exp_ready && bus.in_valid) begin
            if (bus.in_vec == '0) zerr_exp = 1'b1;
            for (int b = 0; b < IN_W; b++)
               if (bus.in_vec[b]) q_codes.push_back(b);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int codes_8421[4];
      int beat;
      codes_8421[0] = 0; codes_8421[1] = 5; codes_8421[2] = 10; codes_8421[3] = 15;

      rst_n         = 1'b0;
      bus.enable    = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_vec    = 16'h00FF;
      bus.out_ready = 1'b1;

      // Reset state, with enable and in_valid high throughout.
      @(negedge clk);
      check("rst_in_ready",  32'(bus.in_ready),  32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_code",  32'(bus.out_code),  32'd0);
      check("rst_out_last",  32'(bus.out_last),  32'd0);
      check("rst_zero_err",  32'(bus.zero_err),  32'd0);
      tick();
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Single bit vector.
      tick();
      bus.in_valid = 1'b1; bus.in_vec = 16'h0001;
      tick();
      bus.in_valid = 1'b0; bus.in_vec = 16'hFFFF;
      @(negedge clk);
      check("one_valid", 32'(bus.out_valid), 32'd1);
      check("one_code",  32'(bus.out_code),  32'd0);
      check("one_last",  32'(bus.out_last),  32'd1);
      check("one_ready", 32'(bus.in_ready),  32'd0);
      tick();
      @(negedge clk);
      check("one_done_valid", 32'(bus.out_valid), 32'd0);
      check("one_done_ready", 32'(bus.in_ready),  32'd1);

      // 8421 streamed at full rate.
      tick();
      bus.in_valid = 1'b1; bus.in_vec = 16'h8421;
      tick();
      bus.in_valid = 1'b0; bus.in_vec = 16'h0003;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("s8421_code", 32'(bus.out_code), 32'(codes_8421[i]));
         check("s8421_last", 32'(bus.out_last), 32'(i == 3));
         tick();
      end
      @(negedge clk);
      check("s8421_end", 32'(bus.out_valid), 32'd0);

      // All-zero vector.
      tick();
      bus.in_valid = 1'b1; bus.in_vec = 16'h0000;
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("zero_err_hi", 32'(bus.zero_err),  32'd1);
      check("zero_valid",  32'(bus.out_valid), 32'd0);
      check("zero_ready",  32'(bus.in_ready),  32'd1);
      tick();
      @(negedge clk);
      check("zero_err_lo", 32'(bus.zero_err), 32'd0);

      // FFFF with out_ready toggling every cycle.
      tick();
      bus.in_valid = 1'b1; bus.in_vec = 16'hFFFF;
      tick();
      bus.in_valid = 1'b0;
      beat = 0;
      for (int c = 0; c < 64 && beat < 16; c++) begin
         bus.out_ready = c[0];
         @(negedge clk);
         check("ffff_code", 32'(bus.out_code), 32'(beat));
         check("ffff_last", 32'(bus.out_last), 32'(beat == 15));
         if (bus.out_valid && bus.out_ready) beat++;
         tick();
      end
      check("ffff_beats", 32'(beat), 32'd16);
      bus.out_ready = 1'b1;

      // 00F0 interrupted by reset after codes 4 and 5.
      tick();
      bus.in_valid = 1'b1; bus.in_vec = 16'h00F0;
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("f0_code4", 32'(bus.out_code), 32'd4);
      tick();
      @(negedge clk);
      check("f0_code5", 32'(bus.out_code), 32'd5);
      tick();
      rst_n = 1'b0;
      #1;
      check("f0_rst_valid", 32'(bus.out_valid), 32'd0);
      check("f0_rst_ready", 32'(bus.in_ready),  32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("f0_no_residue", 32'(bus.out_valid), 32'd0);
         tick();
      end

      // enable low blocks acceptance; raising it accepts that same cycle.
      bus.enable = 1'b0; bus.in_valid = 1'b1; bus.in_vec = 16'h0006;
      @(negedge clk);
      check("en0_ready", 32'(bus.in_ready), 32'd0);
      tick();
      tick();
      @(negedge clk);
      check("en0_valid", 32'(bus.out_valid), 32'd0);
      tick();
      bus.enable = 1'b1;
      @(negedge clk);
      check("en1_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0; bus.enable = 1'b0;
      @(negedge clk);
      check("en1_valid", 32'(bus.out_valid), 32'd1);
      check("en1_code",  32'(bus.out_code),  32'd1);
      tick();
      tick();
      bus.enable = 1'b1;

      // Randomized traffic checked by the model.
      for (int c = 0; c < 600; c++) begin
         int sel;
         sel = $urandom_range(0, 3);
         bus.enable    = ($urandom_range(0, 7) != 0);
         bus.in_valid  = $urandom_range(0, 1);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         case (sel)
            0:       bus.in_vec = '0;
            1:       bus.in_vec = IN_W'(1) << $urandom_range(0, IN_W - 1);
            default: bus.in_vec = IN_W'($urandom);
         endcase
         rst_n = ($urandom_range(0, 99) != 0);
         tick();
      end
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/priority_encoder_scan.md
PRIORITY_ENCODER_SCAN -- requirements
Module: priority_encoder_scan

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, giving the width of the one-hot or multi-hot input vector.
REQ-002 The block SHALL have parameter OUT_W, default 4, giving the width of the binary index output; IN_W SHALL equal 2**OUT_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port enable, input, 1 bit: gates acceptance of new vectors.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream vector valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a vector.
REQ-008 The block SHALL have port in_vec, input, IN_W bits: vector to encode.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_code valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_code.
REQ-011 The block SHALL have port out_code, output, OUT_W bits: binary index of one set bit.
REQ-012 The block SHALL have port out_last, output, 1 bit: current code is the final set bit of the vector.
REQ-013 The block SHALL have port zero_err, output, 1 bit: one-cycle pulse when an all-zero vector is accepted.

Function
REQ-014 The block SHALL implement two states: IDLE and EMIT.
REQ-015 In IDLE, in_ready SHALL equal enable; in EMIT, in_ready SHALL be 0.
REQ-016 An input handshake (in_valid && in_ready) with in_vec != 0 SHALL load in_vec into an IN_W-bit pending register and move to EMIT on the same edge.
REQ-017 An input handshake with in_vec == 0 SHALL assert zero_err for exactly the next cycle, keep state IDLE and leave pending at 0.
REQ-018 In EMIT, out_valid SHALL be 1; in IDLE, out_valid SHALL be 0.
REQ-019 out_code SHALL be the index of the lowest-numbered set bit of pending, so bit 0 has the highest priority.
REQ-020 out_last SHALL be 1 exactly when pending has a single set bit.
REQ-021 Latency: first out_valid SHALL assert in the cycle after input acceptance; with out_ready held at 1, one code SHALL be emitted per cycle.
REQ-022 On an output handshake (out_valid && out_ready), the emitted bit SHALL be cleared from pending.
REQ-023 If that handshake has out_last=1, the state SHALL return to IDLE; in_ready SHALL rise no earlier than the following cycle.
REQ-024 While out_valid=1 and out_ready=0, out_code, out_last and pending SHALL hold stable.
REQ-025 Deasserting enable during EMIT SHALL NOT abort the in-flight vector; it only blocks the next acceptance.
REQ-026 in_vec SHALL be ignored outside an input handshake; changing in_vec during EMIT SHALL NOT affect the codes being emitted.
REQ-027 The number of output beats per vector SHALL equal the popcount of the accepted vector, in ascending index order.

Reset
REQ-028 While rst_n=0, the block SHALL hold: state IDLE, pending 0, out_valid 0, out_code 0, out_last 0, zero_err 0, in_ready 0.
REQ-029 Asserting rst_n low mid-EMIT SHALL immediately drop out_valid and discard the pending bits, with no residual beats after release.
REQ-030 After rst_n rises, in_ready SHALL follow enable from the first clock edge.

Verification
REQ-031 in_vec=16'h0001 accepted -> one beat, out_code=0, out_last=1, then in_ready=1 two cycles after acceptance.
REQ-032 in_vec=16'h8421 with out_ready=1 -> out_code 0, 5, 10, 15 on consecutive cycles, out_last only on 15.
REQ-033 in_vec=16'h0000 accepted -> zero_err=1 for one cycle, out_valid stays 0, in_ready stays 1.
REQ-034 in_vec=16'hFFFF with out_ready toggling every cycle -> 16 beats with codes 0 to 15, each held stable while out_ready=0, out_last on 15.
REQ-035 in_vec=16'h00F0 accepted, rst_n pulled low after 2 beats (codes 4, 5) -> out_valid=0 at once; after release no codes 6 or 7 appear.
REQ-036 enable=0 with in_valid=1 -> in_ready=0 and no acceptance; enable raised -> vector accepted that cycle and first code one cycle later.
